// File: rtl/multiply_constant_serial.sv
// Serial shift-and-add multiplier by an elaboration-time constant.
// One constant bit is processed per cycle, so latency is fixed at CONST_WIDTH
// cycles no matter what the constant's bit pattern is. Operands come in and
// results go out through valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// CALC  | accumulating one constant bit per cycle
// DONE  | result held on mul until out_ready
module multiply_constant_serial #(
  parameter int WIDTH       = 8,
  parameter int CONST_WIDTH = 5,
  parameter int CONST       = 17
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH+CONST_WIDTH-1:0] mul,
  output logic                         busy
);

  localparam int PW    = WIDTH + CONST_WIDTH;
  localparam int CNT_W = (CONST_WIDTH > 1) ? $clog2(CONST_WIDTH) : 1;
  localparam logic [CONST_WIDTH-1:0] CONST_BITS = CONST_WIDTH'(CONST);
  localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(CONST_WIDTH - 1);

  // Reject constants that do not fit in CONST_WIDTH bits.
  if (CONST < 0 || (CONST_WIDTH < 31 && CONST >= (1 << CONST_WIDTH))) begin : g_const_check
    $error("multiply_constant_serial: CONST does not fit in CONST_WIDTH bits");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mul_q, mul_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     addend;

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      mul_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      mul_q   <= mul_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and accumulate logic; the last CALC edge loads mul directly
  // with the final sum so it is valid the same cycle out_valid rises.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    acc_d   = acc_q;
    mul_d   = mul_q;
    cnt_d   = cnt_q;
    addend  = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (CONST_BITS[cnt_q]) begin
          addend = PW'(a_q) << cnt_q;
        end
        acc_d = acc_q + addend;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          mul_d   = acc_d;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode straight from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    mul       = mul_q;
  end

endmodule

// File: tb/tb_multiply_constant_serial.sv
module tb_multiply_constant_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [7:0]  a;
  logic        in_ready, out_valid, busy;
  logic [12:0] mul;

  logic        in_valid2, out_ready2;
  logic [7:0]  a2;
  logic        in_ready_f, out_valid_f, busy_f;
  logic [15:0] mul_f;
  logic        in_ready_z, out_valid_z, busy_z;
  logic [15:0] mul_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiply_constant_serial dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .mul(mul), .busy(busy)
  );

  multiply_constant_serial #(.WIDTH(8), .CONST_WIDTH(8), .CONST(255)) dut_full (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready_f), .a(a2),
    .out_valid(out_valid_f), .out_ready(out_ready2), .mul(mul_f), .busy(busy_f)
  );

  multiply_constant_serial #(.WIDTH(8), .CONST_WIDTH(8), .CONST(0)) dut_zero (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready_z), .a(a2),
    .out_valid(out_valid_z), .out_ready(out_ready2), .mul(mul_z), .busy(busy_z)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid on the default instance; returns cycles waited.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) check("timeout_out_valid", 0, 1);
  endtask

  // Reference model and scoreboard for the random phase.
  int unsigned ref_q[$];
  bit          mon_en = 1'b0;
  int          n_recv = 0;

  always @(posedge clk) begin
    if (mon_en && !rst) begin
      if (out_valid && out_ready) begin
        if (ref_q.size() == 0) begin
          check("rand_unexpected_result", 1, 0);
        end else begin
          check("rand_mul", 32'(mul), ref_q.pop_front() * 17);
        end
        n_recv++;
      end
      if (in_valid && in_ready) ref_q.push_back(32'(a));
    end
  end

  typedef struct {
    logic [7:0] av;
    int         exp_mul;
  } vec_t;

  vec_t vecs[6];
  int   lat;
  int   done_t[$];

  initial begin
    vecs[0] = '{8'hFF, 4335};
    vecs[1] = '{8'h0F, 255};
    vecs[2] = '{8'h00, 0};
    vecs[3] = '{8'd100, 1700};
    vecs[4] = '{8'h01, 17};
    vecs[5] = '{8'h80, 2176};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_mul", 32'(mul), 0);

    // Table-driven vectors with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = vecs[i].av;
      tick();
      in_valid = 1'b0;
      check("vec_busy_calc", 32'(busy), 1);
      wait_done(lat);
      check("vec_latency", lat, 5);
      check("vec_mul", 32'(mul), vecs[i].exp_mul);
      check("vec_in_ready_done", 32'(in_ready), 0);
      tick();
      check("vec_back_idle", 32'(in_ready), 1);
      check("vec_out_valid_low", 32'(out_valid), 0);
    end

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd100;
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_mul", 32'(mul), 1700);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 32'(in_ready), 1);
    check("bp_release_out_valid", 32'(out_valid), 0);

    // Overlap rejection: in_valid stays high while a changes every cycle.
    in_valid = 1'b1; a = 8'd5;
    tick();
    lat = 0;
    while (!out_valid && lat < 40) begin
      a = 8'($urandom);
      tick();
      lat++;
    end
    check("ovl_mul_first", 32'(mul), 85);
    a = 8'($urandom);
    tick();
    check("ovl_idle", 32'(in_ready), 1);
    a = 8'd9;
    tick();
    lat = 0;
    while (!out_valid && lat < 40) begin
      a = 8'($urandom);
      tick();
      lat++;
    end
    check("ovl_mul_second", 32'(mul), 153);
    in_valid = 1'b0;
    tick();

    // Reset during the third CALC cycle discards the operation.
    in_valid = 1'b1; a = 8'd200;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_in_ready", 32'(in_ready), 1);
    check("rstmid_out_valid", 32'(out_valid), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_mul", 32'(mul), 0);
    in_valid = 1'b1; a = 8'd3;
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    check("rstmid_lat", lat, 5);
    check("rstmid_mul_after", 32'(mul), 51);
    tick();

    // Reparametrised instances: CONST=255 and CONST=0, 8-cycle latency.
    for (int i = 0; i < 2; i++) begin
      a2 = (i == 0) ? 8'hFF : 8'hAA;
      in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      lat = 0;
      while (!out_valid_f && lat < 40) begin
        tick();
        lat++;
      end
      check("full_lat", lat, 8);
      check("full_mul", 32'(mul_f), 32'(a2) * 255);
      check("zero_valid", 32'(out_valid_z), 1);
      check("zero_mul", 32'(mul_z), 0);
      tick();
    end

    // Unthrottled throughput: one result every 7 cycles.
    in_valid = 1'b1; a = 8'd2;
    for (int c = 0; c < 60 && done_t.size() < 3; c++) begin
      tick();
      if (out_valid) done_t.push_back(c);
    end
    in_valid = 1'b0;
    check("thru_count", done_t.size(), 3);
    if (done_t.size() == 3) begin
      check("thru_gap0", done_t[1] - done_t[0], 7);
      check("thru_gap1", done_t[2] - done_t[1], 7);
    end
    check("thru_mul", 32'(mul), 34);
    while (busy) tick();

    // Random streaming with gaps on both sides against the reference model.
    begin
      int  n_sent;
      int  cyc;
      bit  fire;
      n_sent = 0;
      cyc = 0;
      ref_q.delete();
      n_recv = 0;
      mon_en = 1'b1;
      while (n_recv < 200 && cyc < 20000) begin
        fire = in_valid && in_ready;
        tick();
        cyc++;
        if (fire) begin
          n_sent++;
          in_valid = 1'b0;
        end
        if (!in_valid && n_sent < 200 && $urandom_range(0, 2) != 0) begin
          in_valid = 1'b1;
          a = 8'($urandom);
        end
        out_ready = ($urandom_range(0, 3) != 0);
      end
      mon_en = 1'b0;
      in_valid = 1'b0;
      check("rand_received", n_recv, 200);
      check("rand_sent", n_sent, 200);
      check("rand_queue_empty", ref_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiply_constant_serial.md
Name: multiply_constant_serial

Overview:
Parametrised successor to the team's fixed multiply-by-17 block. It multiplies a WIDTH-bit unsigned operand by an elaboration-time constant CONST using serial shift-and-add, handling one constant bit per cycle. Operands arrive and results leave through valid/ready handshakes, so the block drops into streaming datapaths. It trades area for latency; the fully combinational constant multipliers remain the choice where single-cycle results are required.

Parameters:
WIDTH, 8, operand width in bits (>=1)
CONST_WIDTH, 5, bit width of the constant; also the number of calculation cycles (>=1)
CONST, 17, unsigned multiplier constant; must satisfy CONST < 2**CONST_WIDTH (elaboration error otherwise)

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand a is valid
in_ready  output  1  block can accept an operand this cycle
a  input  WIDTH  unsigned operand
out_valid  output  1  mul holds a valid result
out_ready  input  1  downstream accepts mul this cycle
mul  output  WIDTH+CONST_WIDTH  unsigned product a*CONST, zero-extended
busy  output  1  high in CALC or DONE

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. With rst high at a rising edge: state=IDLE, in_ready=1, out_valid=0, busy=0, mul=0, internal accumulator=0, bit counter=0. rst overrides every other input, including mid-CALC and in DONE; any in-flight result is discarded.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: capture a into a_reg, clear accumulator, set counter=0, go to CALC.
- CALC:
  - in_ready=0.
  - Each edge: if CONST[cnt]=1, acc <= acc + (a_reg << cnt); otherwise acc is unchanged. Then cnt <= cnt+1.
  - The edge processing cnt==CONST_WIDTH-1 moves the FSM to DONE and loads mul with the final sum.
  - CALC lasts exactly CONST_WIDTH cycles regardless of CONST's bit pattern or the value of a (fixed latency).
- DONE:
  - out_valid=1; mul is stable and held until the handshake completes.
  - On an edge with out_ready=1: go to IDLE. mul keeps its value, but it is meaningless while out_valid=0.
  - in_ready=0 in DONE, so no new operand is accepted in the handshake cycle.
- Latency: out_valid rises CONST_WIDTH cycles after the acceptance edge. Minimum issue interval is CONST_WIDTH+2 cycles, with out_ready held high.
- Arithmetic:
  - acc is WIDTH+CONST_WIDTH bits. The maximum product (2**WIDTH-1)*(2**CONST_WIDTH-1) fits this width, so there is no overflow or truncation.
  - Shifted addends are zero-extended to acc width.
- Boundaries:
  - CONST=0: result 0 after the full CONST_WIDTH cycles.
  - a=0: result 0.
  - in_valid asserted in CALC or DONE: ignored; the upstream source must hold its data (standard valid/ready).
  - out_ready high before out_valid: no effect.
  - out_ready low: stays in DONE indefinitely with mul constant.
- Counter width: clog2(CONST_WIDTH), minimum 1 bit; it must not wrap before reaching CONST_WIDTH-1.

Test Plan:
- Defaults (WIDTH=8, CONST_WIDTH=5, CONST=17), a=8'hFF, out_ready=1 -> out_valid exactly 5 cycles after acceptance, mul=16'd4335; a=8'h0F -> 255; a=0 -> 0.
- Backpressure: a=8'd100, out_ready held low for 10 cycles -> out_valid stays 1, mul=1700 stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
- Overlap rejection: in_valid held high with a changing every cycle -> only the value present at the IDLE acceptance edge is used; later values are ignored until the next IDLE.
- Reset mid-operation: assert rst on the 3rd CALC cycle -> next cycle IDLE, out_valid=0, mul=0, busy=0; a fresh a=8'd3 then yields 51.
- Reparametrised WIDTH=8, CONST_WIDTH=8, CONST=255: a=8'hFF -> mul=16'd65025 (max, no overflow) after 8 cycles. CONST=0: a=8'hAA -> mul=0 after 8 cycles.
- Back-to-back: 200 random operands with random in_valid/out_ready gaps versus a reference product -> all match, no drops or duplicates, throughput of 1 result per 7 cycles when unthrottled (defaults).
